// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// The stall logic decodes md_op with the same encodings.
package md_unit_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// Combinational 32-bit quotient/remainder, signed or unsigned.
// Divide by zero gives q=all-ones, r=dividend.
module md_div_core (
    input  logic        sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic [31:0] r
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] uq;
    logic [31:0] ur;

    assign neg_a = sgn & a[31];
    assign neg_b = sgn & b[31];
    assign ua    = neg_a ? (~a + 32'd1) : a;
    assign ub    = neg_b ? (~b + 32'd1) : b;

    // Overflow (min / -1) falls out of the magnitude path as 0x80000000.
    always_comb begin
        uq = '0;
        ur = '0;
        q  = '1;
        r  = a;
        if (b != '0) begin
            uq = ua / ub;
            ur = ua % ub;
            q  = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
            r  = neg_a ? (~ur + 32'd1) : ur;
        end
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit with private HI/LO registers.
// Fixed-latency ops stage their result and commit it on the last busy cycle.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e   state;
    logic [3:0]  cnt;
    logic [31:0] hi_n;
    logic [31:0] lo_n;

    logic        msgn;
    logic [63:0] prod;
    logic [31:0] dq;
    logic [31:0] dr;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic [3:0]  lat;

    // Sign-extend to 64 bits so one unsigned multiplier serves both forms.
    assign msgn = (md_op == MD_MULT);
    assign prod = {{32{msgn & A[31]}}, A} * {{32{msgn & B[31]}}, B};

    md_div_core u_div (
        .sgn (md_op == MD_DIV),
        .a   (A),
        .b   (B),
        .q   (dq),
        .r   (dr)
    );

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        lat    = 4'(MUL_LAT);
        if (md_op == MD_DIV || md_op == MD_DIVU) begin
            res_hi = dr;
            res_lo = dq;
            lat    = 4'(DIV_LAT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi_n  <= '0;
            lo_n  <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        hi_n  <= res_hi;
                        lo_n  <= res_lo;
                        cnt   <= lat;
                        state <= ST_RUN;
                    end else if (!cancel) begin
                        if (mt_hi) HI <= A;
                        if (mt_lo) LO <= A;
                    end
                end
                ST_RUN: begin
                    if (cnt == 4'd1) begin
                        HI    <= hi_n;
                        LO    <= lo_n;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: scoreboard of expected HI/LO per op,
// cycle-exact busy window and HI/LO hold checks.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mt_hi;
    logic        mt_lo;
    logic        cancel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .mt_hi  (mt_hi),
        .mt_lo  (mt_lo),
        .cancel (cancel),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stall logic must never let HI/LO instructions reach E while busy.
    always @(posedge clk) begin
        if (!reset && busy === 1'b1) begin
            checks++;
            if (start || mt_hi || mt_lo) begin
                errors++;
                $display("FAIL busy_issue: start=%b mt_hi=%b mt_lo=%b, required all 0",
                         start, mt_hi, mt_lo);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        longint sa;
        longint sb_;
        longint q;
        longint r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (op)
            2'b00: return 64'(sa * sb_);
            2'b01: return ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (op == 2'b10) begin
                    q = sa / sb_;
                    r = sa % sb_;
                    return {r[31:0], q[31:0]};
                end
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] ehi, logic [31:0] elo);
        exp_t e;
        e.hi  = ehi;
        e.lo  = elo;
        e.lat = op[1] ? 10 : 5;
        sb.push_back(e);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        mt_hi = 1'b0;
        mt_lo = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, HI, LO} !== {1'b0, 64'd0}) begin
            errors++;
            $display("FAIL reset: busy=%b HI=%h LO=%h, required 0/0/0", busy, HI, LO);
        end
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_ops();
        logic [1:0]  ops[11];
        logic [31:0] as[11];
        logic [31:0] bs[11];
        logic [63:0] ex[11];
        exp_t        e;
        ops[0] = 2'b00; as[0] = 32'hFFFFFFFD; bs[0] = 32'd5;
        ex[0] = {32'hFFFFFFFF, 32'hFFFFFFF1};
        ops[1] = 2'b01; as[1] = 32'hFFFFFFFF; bs[1] = 32'hFFFFFFFF;
        ex[1] = {32'hFFFFFFFE, 32'h00000001};
        ops[2] = 2'b10; as[2] = 32'hFFFFFFF9; bs[2] = 32'd2;
        ex[2] = {32'hFFFFFFFF, 32'hFFFFFFFD};
        ops[3] = 2'b11; as[3] = 32'h12345678; bs[3] = 32'd0;
        ex[3] = {32'h12345678, 32'hFFFFFFFF};
        ops[4] = 2'b10; as[4] = 32'h80000000; bs[4] = 32'hFFFFFFFF;
        ex[4] = {32'h00000000, 32'h80000000};
        ops[5] = 2'b10; as[5] = 32'h80000005; bs[5] = 32'd0;
        ex[5] = {32'h80000005, 32'hFFFFFFFF};
        for (int i = 6; i < 11; i++) begin
            ops[i] = 2'($urandom_range(0, 3));
            as[i]  = $urandom;
            bs[i]  = (i == 8) ? 32'($urandom_range(1, 9)) : $urandom;
            ex[i]  = model(ops[i], as[i], bs[i]);
        end
        for (int i = 0; i < 11; i++) begin
            issue(ops[i], as[i], bs[i], ex[i][63:32], ex[i][31:0]);
            e = sb.pop_front();
            for (int c = 0; c < e.lat; c++) begin
                checks++;
                if ({busy, HI, LO} !== {1'b1, m_hi, m_lo}) begin
                    errors++;
                    $display("FAIL op%0d_run c%0d: busy=%b HI=%h LO=%h, required 1/%h/%h",
                             i, c, busy, HI, LO, m_hi, m_lo);
                end
                tick();
            end
            checks++;
            if ({busy, HI, LO} !== {1'b0, e.hi, e.lo}) begin
                errors++;
                $display("FAIL op%0d_done: busy=%b HI=%h LO=%h, required 0/%h/%h",
                         i, busy, HI, LO, e.hi, e.lo);
            end
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    task automatic test_mt();
        mt_hi = 1'b1;
        A     = 32'hDEADBEEF;
        tick();
        mt_hi = 1'b0;
        checks++;
        if ({busy, HI, LO} !== {1'b0, 32'hDEADBEEF, m_lo}) begin
            errors++;
            $display("FAIL mthi: busy=%b HI=%h LO=%h, required 0/deadbeef/%h",
                     busy, HI, LO, m_lo);
        end
        mt_lo = 1'b1;
        A     = 32'h1;
        tick();
        mt_lo = 1'b0;
        checks++;
        if ({busy, HI, LO} !== {1'b0, 32'hDEADBEEF, 32'h1}) begin
            errors++;
            $display("FAIL mtlo: busy=%b HI=%h LO=%h, required 0/deadbeef/00000001",
                     busy, HI, LO);
        end
        m_hi = 32'hDEADBEEF;
        m_lo = 32'h1;
        mt_hi  = 1'b1;
        mt_lo  = 1'b1;
        cancel = 1'b1;
        A      = 32'h55AA55AA;
        tick();
        mt_hi  = 1'b0;
        mt_lo  = 1'b0;
        cancel = 1'b0;
        checks++;
        if ({HI, LO} !== {m_hi, m_lo}) begin
            errors++;
            $display("FAIL mt_cancel: HI=%h LO=%h, required %h/%h", HI, LO, m_hi, m_lo);
        end
    endtask

    task automatic test_cancel();
        start  = 1'b1;
        cancel = 1'b1;
        md_op  = 2'b00;
        A      = 32'd7;
        B      = 32'd9;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        for (int c = 0; c < 7; c++) begin
            checks++;
            if ({busy, HI, LO} !== {1'b0, m_hi, m_lo}) begin
                errors++;
                $display("FAIL cancel c%0d: busy=%b HI=%h LO=%h, required 0/%h/%h",
                         c, busy, HI, LO, m_hi, m_lo);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if ({busy, HI, LO} !== {1'b0, 64'd0}) begin
                errors++;
                $display("FAIL reset_mid c%0d: busy=%b HI=%h LO=%h, required 0/0/0",
                         c, busy, HI, LO);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        issue(2'b00, 32'd6, 32'd7, 32'd0, 32'd42);
        e = sb.pop_front();
        for (int c = 0; c < e.lat; c++) tick();
        checks++;
        if ({busy, HI, LO} !== {1'b0, e.hi, e.lo}) begin
            errors++;
            $display("FAIL b2b_first: busy=%b HI=%h LO=%h, required 0/%h/%h",
                     busy, HI, LO, e.hi, e.lo);
        end
        m_hi = e.hi;
        m_lo = e.lo;
        mt_hi = 1'b1;
        mt_lo = 1'b1;
        issue(2'b11, 32'd1000, 32'd7, 32'd6, 32'd142);
        e = sb.pop_front();
        for (int c = 0; c < e.lat; c++) begin
            checks++;
            if ({busy, HI, LO} !== {1'b1, m_hi, m_lo}) begin
                errors++;
                $display("FAIL b2b_run c%0d: busy=%b HI=%h LO=%h, required 1/%h/%h",
                         c, busy, HI, LO, m_hi, m_lo);
            end
            tick();
        end
        checks++;
        if ({busy, HI, LO} !== {1'b0, e.hi, e.lo}) begin
            errors++;
            $display("FAIL b2b_second: busy=%b HI=%h LO=%h, required 0/%h/%h",
                     busy, HI, LO, e.hi, e.lo);
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        md_op  = 2'b00;
        A      = '0;
        B      = '0;
        mt_hi  = 1'b0;
        mt_lo  = 1'b0;
        cancel = 1'b0;
        m_hi   = '0;
        m_lo   = '0;
        #1;
        test_reset();
        test_ops();
        test_mt();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
